// File: rtl/display_arbiter.sv
// display_arbiter: shares the display command port among NREQ requesters, round-robin.
// Define DISPLAY_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module display_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_cmd,
    input  logic [48*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [3:0]           disp_cmd,
    output logic [47:0]          disp_data,
    input  logic                 disp_ready,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] cand;
    logic            hit_hi;
    logic            hit_lo;
    logic            found;
    logic            prio_win;
    logic            accept;
    logic            is_nop;
    logic [IDW-1:0]  win_hi;
    logic [IDW-1:0]  win_lo;
    logic [IDW-1:0]  win;
    logic [3:0]      sel_cmd;
    logic [47:0]     sel_data;

    // A requester acknowledged this cycle is still holding its old request.
    assign masked = req_valid & ~req_ack;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cand     = masked;
        prio_win = 1'b0;
`ifdef DISPLAY_ARB_PRIO0_EN
        cand[0]  = 1'b0;
        prio_win = masked[0];
`endif
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        win_hi = '0;
        win_lo = '0;
        // Descending scan so the lowest index at/above rr_ptr (or below it, on wrap) is kept.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (cand[j]) begin
                if (j >= int'(rr_ptr)) begin
                    hit_hi = 1'b1;
                    win_hi = IDW'(j);
                end else begin
                    hit_lo = 1'b1;
                    win_lo = IDW'(j);
                end
            end
        end
        found = prio_win | hit_hi | hit_lo;
        if (prio_win)
            win = '0;
        else if (hit_hi)
            win = win_hi;
        else
            win = win_lo;
    end

    always_comb begin
        sel_cmd  = '0;
        sel_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win == IDW'(j)) begin
                sel_cmd  = req_cmd[4*j +: 4];
                sel_data = req_data[48*j +: 48];
            end
        end
    end

    assign accept = ((state == IDLE) || (state == WAIT)) && disp_ready && found;
    assign is_nop = (sel_cmd == 4'h0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !is_nop)
                    state_next = ISSUE;
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (disp_ready)
                    state_next = (accept && !is_nop) ? ISSUE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            disp_cmd  <= 4'h0;
            disp_data <= '0;
            req_ack   <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            disp_cmd <= (state_next == ISSUE) ? sel_cmd : 4'h0;
            req_ack  <= accept ? (NREQ'(1) << win) : '0;
            if (accept) begin
                grant_id <= win;
                if (!prio_win)
                    rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            if (accept && !is_nop)
                disp_data <= sel_data;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: stimulus queues expected grants, a negedge monitor checks them.
module tb_display_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [4*NREQ-1:0]  req_cmd;
    logic [48*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ack;
    logic [3:0]         disp_cmd;
    logic [47:0]        disp_data;
    logic               disp_ready;
    logic               busy;
    logic [IDW-1:0]     grant_id;

    logic [3:0]  cmd_a  [NREQ];
    logic [47:0] data_a [NREQ];
    logic        ready_en;
    int          busy_len;
    int          busy_cnt;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        logic [3:0]     ack;
        logic [3:0]     cmd;
        logic [47:0]    data;
        logic [IDW-1:0] gid;
        int             at;
    } exp_t;

    exp_t sb[$];

    display_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .disp_cmd   (disp_cmd),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_cmd  = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_cmd[4*i +: 4]   = cmd_a[i];
            req_data[48*i +: 48] = data_a[i];
        end
    end

    // Display model: ready only when idle and cmd==0; stays busy busy_len cycles after a command.
    assign disp_ready = ready_en && (busy_cnt == 0) && (disp_cmd == 4'h0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cnt <= 0;
        else if (disp_cmd != 4'h0)
            busy_cnt <= busy_len;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    task automatic set_req(input logic [1:0] i, input logic v, input logic [3:0] c, input logic [47:0] d);
        req_valid[i] = v;
        cmd_a[i]     = c;
        data_a[i]    = d;
    endtask

    task automatic push(input logic [1:0] w, input logic [3:0] c, input logic [47:0] d, input int at);
        exp_t e;
        e.ack  = 4'b0001 << w;
        e.cmd  = c;
        e.data = d;
        e.gid  = {1'b0, w};
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input logic [1:0] i);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ack[i]) begin
                req_valid[i] = 1'b0;
                return;
            end
        end
        timeout_fail("ack_wait");
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0)
                return;
            @(negedge clk);
        end
        timeout_fail("drain_wait");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        ready_en  = 1'b0;
        busy_len  = 0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            cmd_a[i]  = 4'h0;
            data_a[i] = 48'h0;
        end
        #1;
        check("rst_disp_cmd", 64'(disp_cmd), 64'h0);
        check("rst_disp_data", 64'(disp_data), 64'h0);
        check("rst_req_ack", 64'(req_ack), 64'h0);
        check("rst_grant_id", 64'(grant_id), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every ack pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        logic prev_nz;
        prev_nz = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_ack != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 64'(req_ack), 64'h0);
                    end else begin
                        e = sb.pop_front();
                        check("ack", 64'(req_ack), 64'(e.ack));
                        check("grant_id", 64'(grant_id), 64'(e.gid));
                        check("disp_cmd", 64'(disp_cmd), 64'(e.cmd));
                        if (e.cmd != 4'h0)
                            check("disp_data", 64'(disp_data), 64'(e.data));
                        if (e.at >= 0)
                            check("ack_cycle", 64'(cyc), 64'(e.at));
                    end
                end else if (disp_cmd != 4'h0) begin
                    check("cmd_without_ack", 64'(disp_cmd), 64'h0);
                end
                if (prev_nz && (disp_cmd != 4'h0))
                    check("cmd_pulse_len", 64'(disp_cmd), 64'h0);
                prev_nz = (disp_cmd != 4'h0);
            end else begin
                prev_nz = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] order [5];
        int         base;

        rst_n     = 1'b0;
        ready_en  = 1'b0;
        busy_len  = 0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            cmd_a[i]  = 4'h0;
            data_a[i] = 48'h0;
        end

        // Single request: issue one cycle after sampling, then WAIT, then IDLE.
        do_reset();
        ready_en = 1'b1;
        @(negedge clk);
        set_req(2'd2, 1'b1, 4'h3, 48'h0105_0000_002A);
        push(2'd2, 4'h3, 48'h0105_0000_002A, cyc + 1);
        wait_ack(2'd2);
        @(negedge clk);
        check("t1_cmd_after_issue", 64'(disp_cmd), 64'h0);
        check("t1_busy_in_wait", 64'(busy), 64'h1);
        @(negedge clk);
        check("t1_busy_back_idle", 64'(busy), 64'h0);

        // Contention: all valid, display busy 5 cycles -> spacing of 7 cycles between issues.
`ifdef DISPLAY_ARB_PRIO0_EN
        order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        do_reset();
        ready_en = 1'b1;
        busy_len = 5;
        @(negedge clk);
        set_req(2'd0, 1'b1, 4'h1, 48'hA000_0000_0000);
        set_req(2'd1, 1'b1, 4'h5, 48'hA000_0000_0001);
        set_req(2'd2, 1'b1, 4'hA, 48'hA000_0000_0002);
        set_req(2'd3, 1'b1, 4'hF, 48'hA000_0000_0003);
        base = cyc + 1;
        for (int k = 0; k < 5; k++)
            push(order[k], cmd_a[order[k]], data_a[order[k]], base + 7 * k);
        wait_drain();
        req_valid = '0;
        repeat (10) @(negedge clk);
        check("t2_idle_after", 64'(busy), 64'h0);

        // NOP: acknowledged without issue, then the next requester issues the cycle after.
        do_reset();
        ready_en = 1'b1;
        @(negedge clk);
        set_req(2'd1, 1'b1, 4'h0, 48'h0000_0000_1111);
        set_req(2'd2, 1'b1, 4'h7, 48'hBEEF_0000_0007);
        push(2'd1, 4'h0, 48'h0, cyc + 1);
        push(2'd2, 4'h7, 48'hBEEF_0000_0007, cyc + 2);
        wait_ack(2'd1);
        check("t3_nop_stays_idle", 64'(busy), 64'h0);
        check("t3_nop_no_data", 64'(disp_data), 64'h0);
        wait_ack(2'd2);
        @(negedge clk);
        check("t3_busy_after_issue", 64'(busy), 64'h1);

        // Back-pressure: no ack while the display is not ready; issue one cycle after ready rises.
        do_reset();
        @(negedge clk);
        set_req(2'd0, 1'b1, 4'h9, 48'h0000_9999_0009);
        repeat (20) @(negedge clk);
        check("t4_no_ack", 64'(req_ack), 64'h0);
        check("t4_not_busy", 64'(busy), 64'h0);
        ready_en = 1'b1;
        push(2'd0, 4'h9, 48'h0000_9999_0009, cyc + 1);
        wait_ack(2'd0);
        wait_drain();

        // Reset during the ISSUE cycle drops the command immediately.
        do_reset();
        ready_en = 1'b1;
        @(negedge clk);
        set_req(2'd3, 1'b1, 4'h4, 48'h0000_0000_0444);
        push(2'd3, 4'h4, 48'h0000_0000_0444, cyc + 1);
        @(negedge clk);
        req_valid[3] = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_cmd_dropped", 64'(disp_cmd), 64'h0);
        check("t5_ack_cleared", 64'(req_ack), 64'h0);
        check("t5_grant_cleared", 64'(grant_id), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_busy_after", 64'(busy), 64'h0);
        check("t5_cmd_after", 64'(disp_cmd), 64'h0);
        check("t5_sb_empty", 64'(sb.size()), 64'h0);

        // Requesters 0 and 3 continuously valid.
`ifdef DISPLAY_ARB_PRIO0_EN
        order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        order = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
`endif
        do_reset();
        ready_en = 1'b1;
        @(negedge clk);
        set_req(2'd0, 1'b1, 4'h2, 48'h0000_0000_C000);
        set_req(2'd3, 1'b1, 4'h6, 48'h0000_0000_C003);
        base = cyc + 1;
        for (int k = 0; k < 4; k++)
            push(order[k], cmd_a[order[k]], data_a[order[k]], base + 2 * k);
        wait_drain();
        req_valid = '0;
        repeat (6) @(negedge clk);
        check("t6_sb_empty", 64'(sb.size()), 64'h0);
        check("t6_idle_after", 64'(busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
